// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 2-flop synchronizer, 3-sample majority vote,
// optional parity, 1 or 2 stop bits, one-deep output holding register with overrun.
module uart_rx_cfg #(
  parameter int unsigned CLKS_PER_BIT = 87,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_serial,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned IDX_W = 4;
  localparam logic [CNT_W-1:0] CNT_MID   = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] CNT_END   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

  state_t                 r_state, w_next;
  logic [1:0]             r_sync;
  logic [2:0]             r_hist;
  logic [CNT_W-1:0]       r_cnt;
  logic [IDX_W-1:0]       r_bit_idx;
  logic [DATA_BITS-1:0]   r_shift;
  logic                   r_par_bad, r_stop_bad;
  logic [DATA_BITS-1:0]   r_data;
  logic                   r_valid, r_par_err, r_frame_err, r_overrun, r_busy;

  logic w_line, w_vote, w_cnt_mid, w_cnt_end, w_par_calc, w_accept;
  logic w_sample, w_cnt_clr, w_bit_clr, w_bit_inc, w_start_ok, w_load;

  assign w_line     = r_sync[1];
  assign w_vote     = (r_hist[0] & r_hist[1]) | (r_hist[0] & r_hist[2]) | (r_hist[1] & r_hist[2]);
  assign w_cnt_mid  = (r_cnt == CNT_MID);
  assign w_cnt_end  = (r_cnt == CNT_END);
  assign w_par_calc = (^r_shift) ^ w_vote;
  assign w_accept   = r_valid & rx_ready;

  // Line synchronizer and vote history
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= 2'b11;
      r_hist <= 3'b111;
    end else begin
      r_sync <= {r_sync[0], rx_serial};
      r_hist <= {r_hist[1:0], w_line};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (!w_line) w_next = S_START;
      S_START: if (w_cnt_mid) w_next = w_vote ? S_IDLE : S_DATA;
      S_DATA:  if (w_cnt_end && (r_bit_idx == LAST_DATA))
                 w_next = (PARITY != 0) ? S_PAR : S_STOP;
      S_PAR:   if (w_cnt_end) w_next = S_STOP;
      S_STOP:  if (w_cnt_end && (r_bit_idx == LAST_STOP)) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_sample   = 1'b0;
    w_start_ok = 1'b0;
    w_cnt_clr  = 1'b0;
    w_bit_clr  = 1'b0;
    w_bit_inc  = 1'b0;
    w_load     = 1'b0;
    case (r_state)
      S_IDLE:  w_cnt_clr = 1'b1;
      S_START: begin
        w_cnt_clr  = w_cnt_mid;
        w_start_ok = w_cnt_mid & ~w_vote;
        w_bit_clr  = w_cnt_mid;
      end
      S_DATA: begin
        w_sample  = w_cnt_end;
        w_cnt_clr = w_cnt_end;
        w_bit_clr = w_cnt_end & (r_bit_idx == LAST_DATA);
        w_bit_inc = w_cnt_end & (r_bit_idx != LAST_DATA);
      end
      S_PAR: begin
        w_sample  = w_cnt_end;
        w_cnt_clr = w_cnt_end;
      end
      S_STOP: begin
        w_sample  = w_cnt_end;
        w_cnt_clr = w_cnt_end;
        w_bit_inc = w_cnt_end;
        w_load    = w_cnt_end & (r_bit_idx == LAST_STOP);
      end
      default: w_cnt_clr = 1'b1;
    endcase
  end

  // Frame engine datapath: never stalls on the consumer
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_par_bad  <= 1'b0;
      r_stop_bad <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_clr ? '0 : r_cnt + CNT_W'(1);
      r_busy <= (w_next != S_IDLE);
      if (w_bit_clr)      r_bit_idx <= '0;
      else if (w_bit_inc) r_bit_idx <= r_bit_idx + IDX_W'(1);
      if (w_start_ok) begin
        r_par_bad  <= 1'b0;
        r_stop_bad <= 1'b0;
      end
      if (w_sample && (r_state == S_DATA)) r_shift <= {w_vote, r_shift[DATA_BITS-1:1]};
      if (w_sample && (r_state == S_PAR))  r_par_bad <= (PARITY == 1) ? ~w_par_calc : w_par_calc;
      if (w_sample && (r_state == S_STOP)) r_stop_bad <= r_stop_bad | ~w_vote;
    end
  end

  // Holding register: a load while a frame is held and not accepted is dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_par_err   <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (w_load && (!r_valid || rx_ready)) begin
        r_data      <= r_shift;
        r_par_err   <= r_par_bad;
        r_frame_err <= r_stop_bad | ~w_vote;
        r_valid     <= 1'b1;
      end else if (w_accept) begin
        r_valid <= 1'b0;
      end
      if (w_load && r_valid && !rx_ready) r_overrun <= 1'b1;
      else if (w_accept)                  r_overrun <= 1'b0;
    end
  end

  assign rx_data    = r_data;
  assign rx_valid   = r_valid;
  assign parity_err = r_par_err;
  assign frame_err  = r_frame_err;
  assign overrun    = r_overrun;
  assign busy       = r_busy;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard bench for uart_rx_cfg: three configurations (8N1, 7E1, 8N2) at 16 clocks per bit.
module tb_uart_rx_cfg;

  localparam int unsigned CPB = 16;

  typedef struct packed {
    logic [8:0] data;
    logic       pe;
    logic       fe;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx_a = 1'b1, rx_b = 1'b1, rx_c = 1'b1;
  logic ready_a = 1'b1, ready_b = 1'b1, ready_c = 1'b1;
  logic [7:0] data_a, data_c;
  logic [6:0] data_b;
  logic valid_a, valid_b, valid_c;
  logic perr_a, perr_b, perr_c;
  logic ferr_a, ferr_b, ferr_c;
  logic ovr_a, ovr_b, ovr_c;
  logic busy_a, busy_b, busy_c;

  int n_cmp = 0;
  int n_err = 0;
  exp_t q_a[$], q_b[$], q_c[$];
  exp_t e_a, e_b, e_c;

  always #5 clk = ~clk;

  uart_rx_cfg #(.CLKS_PER_BIT(CPB)) u_a (
    .clk(clk), .rst(rst), .rx_serial(rx_a), .rx_data(data_a), .rx_valid(valid_a),
    .rx_ready(ready_a), .parity_err(perr_a), .frame_err(ferr_a), .overrun(ovr_a), .busy(busy_a));

  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(2)) u_b (
    .clk(clk), .rst(rst), .rx_serial(rx_b), .rx_data(data_b), .rx_valid(valid_b),
    .rx_ready(ready_b), .parity_err(perr_b), .frame_err(ferr_b), .overrun(ovr_b), .busy(busy_b));

  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) u_c (
    .clk(clk), .rst(rst), .rx_serial(rx_c), .rx_data(data_c), .rx_valid(valid_c),
    .rx_ready(ready_c), .parity_err(perr_c), .frame_err(ferr_c), .overrun(ovr_c), .busy(busy_c));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [8:0] d, input logic pe, input logic fe);
    exp_t e;
    e.data = d;
    e.pe   = pe;
    e.fe   = fe;
    return e;
  endfunction

  task automatic set_line(input int inst, input logic v);
    case (inst)
      0:       rx_a = v;
      1:       rx_b = v;
      default: rx_c = v;
    endcase
  endtask

  // Hold one line level for len cycles, optionally inverting cycle 8 only
  task automatic drive_bit(input int inst, input logic v, input bit glitch, input int len);
    for (int c = 0; c < len; c++) begin
      @(negedge clk);
      set_line(inst, (glitch && c == 8) ? ~v : v);
    end
  endtask

  // pbit < 0: no parity bit. A bad second stop bit goes low for half a bit only,
  // so the line is idle again before the receiver returns to IDLE.
  task automatic send(input int inst, input int nbits, input logic [8:0] data, input int pbit,
                      input int nstop, input logic stop2, input bit glitch);
    drive_bit(inst, 1'b0, 1'b0, CPB);
    for (int i = 0; i < nbits; i++) drive_bit(inst, data[i], glitch, CPB);
    if (pbit >= 0) drive_bit(inst, 1'(pbit), 1'b0, CPB);
    drive_bit(inst, 1'b1, 1'b0, CPB);
    if (nstop == 2) begin
      if (stop2) drive_bit(inst, 1'b1, 1'b0, CPB);
      else begin
        drive_bit(inst, 1'b0, 1'b0, CPB / 2);
        drive_bit(inst, 1'b1, 1'b0, CPB / 2);
      end
    end
    set_line(inst, 1'b1);
  endtask

  // Output monitors: every accepted frame must match the head of its queue
  always @(negedge clk) begin
    if (!rst && valid_a && ready_a) begin
      chk("a_expected_frame", 32'(q_a.size() != 0), 32'd1);
      if (q_a.size() != 0) begin
        e_a = q_a.pop_front();
        chk("a_data", 32'(data_a), 32'(e_a.data));
        chk("a_perr", 32'(perr_a), 32'(e_a.pe));
        chk("a_ferr", 32'(ferr_a), 32'(e_a.fe));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && valid_b && ready_b) begin
      chk("b_expected_frame", 32'(q_b.size() != 0), 32'd1);
      if (q_b.size() != 0) begin
        e_b = q_b.pop_front();
        chk("b_data", 32'(data_b), 32'(e_b.data));
        chk("b_perr", 32'(perr_b), 32'(e_b.pe));
        chk("b_ferr", 32'(ferr_b), 32'(e_b.fe));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && valid_c && ready_c) begin
      chk("c_expected_frame", 32'(q_c.size() != 0), 32'd1);
      if (q_c.size() != 0) begin
        e_c = q_c.pop_front();
        chk("c_data", 32'(data_c), 32'(e_c.data));
        chk("c_perr", 32'(perr_c), 32'(e_c.pe));
        chk("c_ferr", 32'(ferr_c), 32'(e_c.fe));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    logic [6:0] d7;
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_valid_a", 32'(valid_a), 32'd0);
    chk("rst_data_a", 32'(data_a), 32'd0);
    chk("rst_busy_a", 32'(busy_a), 32'd0);
    chk("rst_ovr_a", 32'(ovr_a), 32'd0);
    chk("rst_flags_b", 32'({perr_b, ferr_b}), 32'd0);
    chk("rst_valid_c", 32'(valid_c), 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // 8N1 basic frame, single-cycle valid
    q_a.push_back(mk(9'h0A5, 1'b0, 1'b0));
    send(0, 8, 9'h0A5, -1, 1, 1'b1, 1'b0);
    chk("a_valid_one_cycle", 32'(valid_a), 32'd0);
    repeat (8) @(negedge clk);

    // 7E1: 0x41 has two ones, so parity bit 1 is an error and 0 is not
    d7 = 7'h41;
    q_b.push_back(mk(9'h041, (^d7) ^ 1'b1, 1'b0));
    send(1, 7, 9'h041, 1, 1, 1'b1, 1'b0);
    q_b.push_back(mk(9'h041, (^d7) ^ 1'b0, 1'b0));
    send(1, 7, 9'h041, 0, 1, 1'b1, 1'b0);
    repeat (8) @(negedge clk);

    // 8N2: bad second stop bit still delivers data, then a good frame
    q_c.push_back(mk(9'h03C, 1'b0, 1'b1));
    send(2, 8, 9'h03C, -1, 2, 1'b0, 1'b0);
    repeat (8) @(negedge clk);
    q_c.push_back(mk(9'h03C, 1'b0, 1'b0));
    send(2, 8, 9'h03C, -1, 2, 1'b1, 1'b0);
    repeat (8) @(negedge clk);

    // 4-cycle start glitch must be rejected
    drive_bit(2, 1'b0, 1'b0, 4);
    drive_bit(2, 1'b1, 1'b0, 2);
    chk("c_glitch_busy_hi", 32'(busy_c), 32'd1);
    repeat (30) @(negedge clk);
    chk("c_glitch_busy_lo", 32'(busy_c), 32'd0);
    chk("c_glitch_no_valid", 32'(valid_c), 32'd0);

    // Overrun: second frame dropped while the first is held
    ready_a = 1'b0;
    q_a.push_back(mk(9'h011, 1'b0, 1'b0));
    send(0, 8, 9'h011, -1, 1, 1'b1, 1'b0);
    send(0, 8, 9'h022, -1, 1, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    chk("a_hold_data", 32'(data_a), 32'h11);
    chk("a_hold_valid", 32'(valid_a), 32'd1);
    chk("a_overrun_set", 32'(ovr_a), 32'd1);
    @(posedge clk);
    #1 ready_a = 1'b1;
    repeat (2) @(negedge clk);
    chk("a_overrun_clr", 32'(ovr_a), 32'd0);
    chk("a_valid_clr", 32'(valid_a), 32'd0);
    repeat (8) @(negedge clk);

    // Single-cycle mid-bit pulses are outvoted
    q_a.push_back(mk(9'h05A, 1'b0, 1'b0));
    send(0, 8, 9'h05A, -1, 1, 1'b1, 1'b1);
    repeat (8) @(negedge clk);

    // Reset mid-frame aborts, next frame is received
    drive_bit(0, 1'b0, 1'b0, CPB);
    drive_bit(0, 1'b1, 1'b0, CPB);
    drive_bit(0, 1'b0, 1'b0, CPB);
    @(negedge clk);
    rst = 1'b1;
    set_line(0, 1'b1);
    repeat (3) @(negedge clk);
    chk("a_rst_busy", 32'(busy_a), 32'd0);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("a_rst_no_valid", 32'(valid_a), 32'd0);
    chk("a_rst_idle", 32'(busy_a), 32'd0);
    q_a.push_back(mk(9'h081, 1'b0, 1'b0));
    send(0, 8, 9'h081, -1, 1, 1'b1, 1'b0);

    for (int i = 0; i < 400 && (q_a.size() + q_b.size() + q_c.size()) != 0; i++) @(negedge clk);
    chk("queues_drained", 32'(q_a.size() + q_b.size() + q_c.size()), 32'd0);
    repeat (4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
